// File: rtl/prga_fifo_lookahead_buffer.sv
// rtl/prga_fifo_lookahead_buffer.sv - turns a non-lookahead FIFO read port into a lookahead port
// Optional sticky misuse/overflow flag: define PRGA_FIFO_LOOKAHEAD_BUFFER_CHECK_EN.
module prga_fifo_lookahead_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_i,
  output logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  empty_o,
  input  logic                  rd_o,
  output logic [DATA_WIDTH-1:0] dout_o
`ifdef PRGA_FIFO_LOOKAHEAD_BUFFER_CHECK_EN
  ,
  output logic                  err
`endif
);

  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  head_q, tail_q;
  logic [DATA_WIDTH-1:0] slot_q [2];
  logic                  pop, push;
  logic [2:0]            level;

  always_comb begin
    empty_o = rst || (count_q == 2'd0);
    pop     = rd_o && !empty_o;
    push    = inflight_q;
    // Words already owned (buffered + in flight) once this cycle's pop is taken.
    level   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_i    = !rst && !empty_i && (level <= 3'd1);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    dout_o  = rst ? '0 : slot_q[head_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
    end else begin
      inflight_q <= rd_i;
      count_q    <= count_d;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (push) begin
        slot_q[tail_q] <= dout_i;
        tail_q         <= ~tail_q;
      end
    end
  end

`ifdef PRGA_FIFO_LOOKAHEAD_BUFFER_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((rd_o && empty_o) || (push && (count_q == 2'd2) && !pop)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
